// File: rtl/tb_mailbox_ctrl_if.sv
// AHB-lite write-side bus seen by the mailbox controller. The master drives
// the bus and the controller only observes it.
interface tb_mailbox_ctrl_if;
  logic [1:0]  htrans;
  logic        hready;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;

  modport master (output htrans, hready, hwrite, haddr, hwdata);
  modport slave  (input  htrans, hready, hwrite, haddr, hwdata);
endinterface

// File: rtl/tb_mailbox_ctrl.sv
// Test-bench mailbox controller. It snoops AHB-lite writes and provides:
//  - a character FIFO fed by writes to MBOX_ADDR,
//  - a pass/fail verdict FSM driven by double mark writes,
//  - a 16-word GPR dump window at GPR_BASE.
module tb_mailbox_ctrl #(
  parameter logic [31:0] MBOX_ADDR  = 32'h20007C50,
  parameter logic [31:0] GPR_BASE   = 32'h20007C60,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                   sysclk,
  input  logic                   sysrst_b,
  tb_mailbox_ctrl_if.slave       ahb,
  output logic                   char_valid,
  output logic [7:0]             char_data,
  input  logic                   char_ready,
  output logic                   test_pass,
  output logic                   test_fail,
  input  logic [3:0]             gpr_sel,
  output logic [31:0]            gpr_rdata,
  output logic                   gpr_done,
  output logic                   fifo_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] PASS_MARK = 32'h0000_2002;
  localparam logic [31:0] FAIL_MARK = 32'h0000_1001;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL} state_t;

  // Completed write, valid for the single cycle its data phase finishes.
  typedef struct packed {
    logic        vld;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_req_t;

  logic        pend_q;
  logic [31:0] paddr_q;
  wr_req_t     wr;

  // Address phase captured with hready high; its data phase ends on the next
  // hready-high cycle, which may also capture the following address phase.
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      pend_q  <= 1'b0;
      paddr_q <= '0;
    end else if (ahb.hready) begin
      pend_q <= ahb.htrans[1] && ahb.hwrite;
      if (ahb.htrans[1] && ahb.hwrite) paddr_q <= ahb.haddr;
    end
  end

  assign wr.vld  = pend_q && ahb.hready;
  assign wr.addr = paddr_q;
  assign wr.data = ahb.hwdata;

  // Mailbox decode
  logic mbox_wr, mark_pass, mark_fail, chr_push;
  assign mbox_wr   = wr.vld && (wr.addr == MBOX_ADDR);
  assign mark_pass = mbox_wr && (wr.data == PASS_MARK);
  assign mark_fail = mbox_wr && (wr.data == FAIL_MARK);

  // Verdict FSM
  state_t state_q, state_d;
  logic   pass_arm_q, pass_arm_d, fail_arm_q, fail_arm_d;

  // Verdict state and arming flags
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      state_q    <= ST_IDLE;
      pass_arm_q <= 1'b0;
      fail_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_arm_q <= pass_arm_d;
      fail_arm_q <= fail_arm_d;
    end
  end

  // Second mark of a kind is terminal; non-mark data is a character while live
  always_comb begin
    state_d    = state_q;
    pass_arm_d = pass_arm_q;
    fail_arm_d = fail_arm_q;
    chr_push   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ARMED: begin
        if (mark_pass) begin
          if (pass_arm_q) state_d = ST_PASS;
          else begin
            pass_arm_d = 1'b1;
            state_d    = ST_ARMED;
          end
        end else if (mark_fail) begin
          if (fail_arm_q) state_d = ST_FAIL;
          else begin
            fail_arm_d = 1'b1;
            state_d    = ST_ARMED;
          end
        end else begin
          chr_push = mbox_wr;
        end
      end
      default: ;
    endcase
  end

  assign test_pass = (state_q == ST_PASS);
  assign test_fail = (state_q == ST_FAIL);

  // Character FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign char_valid = (count != '0);
  assign char_data  = mem[rd_ptr];
  assign pop        = char_valid && char_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = chr_push && (!full || pop);

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      if (chr_push && full && !pop) fifo_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until count says so
  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr] <= wr.data[7:0];
  end

  // GPR dump window
  logic [15:0][31:0] gpr;
  logic [31:0]       gpr_off;
  logic              gpr_wr;

  assign gpr_off   = wr.addr - GPR_BASE;
  assign gpr_wr    = wr.vld && (gpr_off[31:6] == '0) && (gpr_off[1:0] == 2'b00);
  assign gpr_rdata = gpr[gpr_sel];

  // GPR update; done flags together with the write of the last word
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      gpr      <= '0;
      gpr_done <= 1'b0;
    end else if (gpr_wr) begin
      gpr[gpr_off[5:2]] <= wr.data;
      if (gpr_off[5:2] == 4'hF) gpr_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tb_mailbox_ctrl.sv
// Scoreboard bench for tb_mailbox_ctrl: expected characters are queued as
// they are written; a negedge monitor checks every FIFO handshake.
module tb_tb_mailbox_ctrl;
  localparam logic [31:0] MBOX = 32'h20007C50;
  localparam logic [31:0] GPRB = 32'h20007C60;

  logic        sysclk = 1'b0;
  logic        sysrst_b = 1'b0;
  logic        char_valid, char_ready = 1'b0;
  logic [7:0]  char_data;
  logic        test_pass, test_fail, gpr_done, fifo_ovf;
  logic [3:0]  gpr_sel = 4'h0;
  logic [31:0] gpr_rdata;

  int n_total = 0;
  int n_pass  = 0;
  int n_pops  = 0;
  logic [7:0] exp_q[$];

  tb_mailbox_ctrl_if ahb_bus ();

  tb_mailbox_ctrl dut (
    .sysclk(sysclk), .sysrst_b(sysrst_b), .ahb(ahb_bus.slave),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .test_pass(test_pass), .test_fail(test_fail),
    .gpr_sel(gpr_sel), .gpr_rdata(gpr_rdata), .gpr_done(gpr_done), .fifo_ovf(fifo_ovf)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Monitor: every handshake must match the scoreboard head
  always @(negedge sysclk) begin
    if (sysrst_b && char_valid && char_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pop: got char %h, required no character", char_data);
      end else begin
        check("char_data", {24'h0, char_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge sysclk); #1;
  endtask

  task automatic bus_idle();
    ahb_bus.htrans = 2'b00; ahb_bus.hwrite = 1'b0; ahb_bus.hready = 1'b1;
    ahb_bus.haddr = '0; ahb_bus.hwdata = '0;
  endtask

  task automatic do_reset();
    sysrst_b = 1'b0; char_ready = 1'b0; bus_idle();
    exp_q.delete();
    repeat (2) step();
    sysrst_b = 1'b1;
    step();
  endtask

  // Single write with optional wait states; pop_at_done raises char_ready
  // only during the completing cycle.
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d,
                           input int waits, input bit pop_at_done);
    ahb_bus.htrans = 2'b10; ahb_bus.hwrite = 1'b1; ahb_bus.haddr = a; ahb_bus.hready = 1'b1;
    step();
    ahb_bus.htrans = 2'b00; ahb_bus.hwrite = 1'b0; ahb_bus.hwdata = d;
    if (waits > 0) begin
      ahb_bus.hready = 1'b0;
      repeat (waits) step();
      ahb_bus.hready = 1'b1;
    end
    if (pop_at_done) char_ready = 1'b1;
    step();
    if (pop_at_done) char_ready = 1'b0;
  endtask

  // Two pipelined writes: second address phase overlaps first data phase
  task automatic ahb_write_pair(input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1);
    ahb_bus.htrans = 2'b10; ahb_bus.hwrite = 1'b1; ahb_bus.haddr = a0; ahb_bus.hready = 1'b1;
    step();
    ahb_bus.htrans = 2'b11; ahb_bus.haddr = a1; ahb_bus.hwdata = d0;
    step();
    ahb_bus.htrans = 2'b00; ahb_bus.hwrite = 1'b0; ahb_bus.hwdata = d1;
    step();
  endtask

  task automatic mbox(input logic [31:0] d, input bit expect_push);
    if (expect_push) exp_q.push_back(d[7:0]);
    ahb_write(MBOX, d, 0, 1'b0);
  endtask

  // Bounded drain: afterwards the scoreboard must be empty and the FIFO idle
  task automatic drain(input string name);
    char_ready = 1'b1;
    repeat (16) step();
    char_ready = 1'b0;
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid_low"}, {31'h0, char_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    do_reset();

    // Reset state
    check("rst_char_valid", {31'h0, char_valid}, 32'd0);
    check("rst_test_pass",  {31'h0, test_pass},  32'd0);
    check("rst_test_fail",  {31'h0, test_fail},  32'd0);
    check("rst_gpr_done",   {31'h0, gpr_done},   32'd0);
    check("rst_fifo_ovf",   {31'h0, fifo_ovf},   32'd0);
    check("rst_gpr_rdata",  gpr_rdata,           32'd0);

    // Two pipelined characters, consumer always ready
    char_ready = 1'b1;
    exp_q.push_back(8'h48); exp_q.push_back(8'h69);
    ahb_write_pair(MBOX, 32'h48, MBOX, 32'h69);
    drain("hi");
    check("hi_pop_count", 32'(n_pops), 32'd2);

    // Pass marks around a character; later character ignored
    do_reset();
    mbox(32'h2002, 1'b0);
    check("pass1_not_yet", {31'h0, test_pass}, 32'd0);
    mbox(32'h41, 1'b1);
    mbox(32'h2002, 1'b0);
    check("pass_set",      {31'h0, test_pass}, 32'd1);
    check("pass_fail_low", {31'h0, test_fail}, 32'd0);
    mbox(32'h42, 1'b0);
    drain("pass");

    // One fail mark does not block a later double pass mark
    do_reset();
    mbox(32'h1001, 1'b0);
    mbox(32'h2002, 1'b0);
    mbox(32'h2002, 1'b0);
    check("mix_pass", {31'h0, test_pass}, 32'd1);
    check("mix_fail", {31'h0, test_fail}, 32'd0);

    // Double fail mark is terminal; pass marks then ignored
    do_reset();
    mbox(32'h1001, 1'b0);
    mbox(32'h1001, 1'b0);
    mbox(32'h2002, 1'b0);
    mbox(32'h2002, 1'b0);
    check("fail_set",       {31'h0, test_fail}, 32'd1);
    check("fail_pass_low",  {31'h0, test_pass}, 32'd0);
    check("fail_no_chars",  {31'h0, char_valid}, 32'd0);

    // Overflow: 8 stored, 9th dropped; then push+pop when full
    do_reset();
    for (int i = 0; i < 8; i++) mbox(32'h30 + 32'(i), 1'b1);
    check("full_no_ovf", {31'h0, fifo_ovf}, 32'd0);
    mbox(32'h39, 1'b0);
    check("ovf_set",   {31'h0, fifo_ovf},   32'd1);
    check("ovf_valid", {31'h0, char_valid}, 32'd1);
    n_pops = 0;
    exp_q.push_back(8'h3A);
    ahb_write(MBOX, 32'h3A, 0, 1'b1);
    check("pushpop_one_pop", 32'(n_pops), 32'd1);
    n_pops = 0;
    drain("ovf");
    check("ovf_remaining_8", 32'(n_pops), 32'd8);

    // GPR dump with 2 wait states per write
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("gpr_done_early", {31'h0, gpr_done}, 32'd0);
      ahb_write(GPRB + 32'(4 * i), 32'(i) * 32'h11111111, 2, 1'b0);
    end
    check("gpr_done_set", {31'h0, gpr_done}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      gpr_sel = 4'(i); #1;
      check($sformatf("gpr_%0d", i), gpr_rdata, 32'(i) * 32'h11111111);
    end
    ahb_write(GPRB + 32'h1, 32'hCAFEF00D, 0, 1'b0);   // unaligned: ignored
    ahb_write(GPRB + 32'h40, 32'hCAFEF00D, 0, 1'b0);  // beyond window
    ahb_write(GPRB + 32'hC, 32'hDEADBEEF, 0, 1'b0);   // still writable
    gpr_sel = 4'h0; #1;
    check("gpr0_unaligned_ignored", gpr_rdata, 32'h0);
    gpr_sel = 4'hF; #1;
    check("gpr15_intact", gpr_rdata, 32'hFFFFFFFF);
    gpr_sel = 4'h3; #1;
    check("gpr3_rewrite", gpr_rdata, 32'hDEADBEEF);

    // Reset in the middle of a pending mailbox write
    mbox(32'h21, 1'b1);
    ahb_bus.htrans = 2'b10; ahb_bus.hwrite = 1'b1; ahb_bus.haddr = MBOX; ahb_bus.hready = 1'b1;
    step();
    ahb_bus.htrans = 2'b00; ahb_bus.hwrite = 1'b0; ahb_bus.hwdata = 32'h55; ahb_bus.hready = 1'b0;
    #2 sysrst_b = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid",    {31'h0, char_valid}, 32'd0);
    check("mid_rst_gpr_done", {31'h0, gpr_done},   32'd0);
    check("mid_rst_gpr",      gpr_rdata,           32'd0);
    check("mid_rst_ovf",      {31'h0, fifo_ovf},   32'd0);
    step();
    ahb_bus.hready = 1'b1;
    sysrst_b = 1'b1;
    repeat (3) step();
    check("post_rst_no_push", {31'h0, char_valid}, 32'd0);
    mbox(32'h77, 1'b1);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
